instr_mem_fetch: RTL and testbench

//  Instruction-memory responder at the far end of the core's PC/fetch interface.
//  - Loads a program serially after reset, then pulses `start` so the PC restarts from address 0.
//  - Serves one fetch per cycle from `fetch_addr`, with a registered 1-cycle response.
//  - Honours `branch_taken` by killing the wrong-path response.

---
 rtl/glorb_pkg.sv | 16 +
 rtl/imem_ram.sv | 32 +++
 rtl/instr_mem_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_mem_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glorb_pkg.sv
// Shared definitions for the instruction-memory fetch slice.
// The package holds the default widths, the LOAD/RUN state type and the NOP encoding.
package glorb_pkg;

    localparam int IW_DEF  = 8;
    localparam int IMW_DEF = 4;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // All-zero instruction word; consumers take the low IW bits.
    localparam logic [63:0] NOP_WORD = 64'h0;

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port block RAM: synchronous write, registered read, no reset on the array.
// It is kept generic so the data memory can reuse it later.
module imem_ram #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory at the far end of the fetch interface: serial program load, then 1-cycle fetches.
// Define IMEM_PARITY_EN to store an even-parity bit per word and expose instr_perr.
module instr_mem_fetch
    import glorb_pkg::*;
#(
    parameter int IW  = IW_DEF,
    parameter int IMW = IMW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [IW-1:0]  load_data,
    input  logic           load_last,
    input  logic           reload,
    output logic           start,
    output logic           running,
    output logic [IMW:0]   prog_len,
    input  logic           fetch_req,
    input  logic [IMW-1:0] fetch_addr,
    input  logic           branch_taken,
    output logic [IW-1:0]  instr_out,
    output logic           instr_valid,
`ifdef IMEM_PARITY_EN
    output logic           instr_perr,
`endif
    output logic           fetch_oob
);

`ifdef IMEM_PARITY_EN
    localparam int RW = IW + 1;
`else
    localparam int RW = IW;
`endif
    localparam logic [IMW-1:0] PTR_MAX = {IMW{1'b1}};

    fetch_state_t   state_q, state_d;
    logic [IMW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IMW:0]   prog_len_q, prog_len_d;
    logic           start_q, start_d;
    logic           load_ready_q, load_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic           nop_sel_q, nop_sel_d;

    logic           load_fire;
    logic           fetch_acc;
    logic           addr_oob;
    logic [RW-1:0]  wr_word;
    logic [RW-1:0]  rd_word;

    assign load_fire = (state_q == LOAD) && load_valid && load_ready_q;
    assign fetch_acc = (state_q == RUN) && fetch_req && !reload;
    assign addr_oob  = ({1'b0, fetch_addr} >= prog_len_q);

`ifdef IMEM_PARITY_EN
    assign wr_word = {^load_data, load_data};
`else
    assign wr_word = load_data;
`endif

    imem_ram #(
        .W  (RW),
        .AW (IMW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (load_fire),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (fetch_acc),
        .rd_addr (fetch_addr),
        .rd_data (rd_word)
    );

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            start_q      <= 1'b0;
            load_ready_q <= 1'b0;
            resp_valid_q <= 1'b0;
            nop_sel_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            start_q      <= start_d;
            load_ready_q <= load_ready_d;
            resp_valid_q <= resp_valid_d;
            nop_sel_q    <= nop_sel_d;
        end
    end

    // The last writable word forces RUN even without load_last so the pointer never wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (load_fire && (load_last || (wr_ptr_q == PTR_MAX))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        prog_len_d   = prog_len_q;
        nop_sel_d    = nop_sel_q;
        resp_valid_d = fetch_acc;
        start_d      = (state_q == LOAD) && (state_d == RUN);
        load_ready_d = (state_d == LOAD);
        if (load_fire) begin
            wr_ptr_d   = wr_ptr_q + IMW'(1);
            prog_len_d = {1'b0, wr_ptr_q} + (IMW + 1)'(1);
        end
        if ((state_q == RUN) && reload) begin
            wr_ptr_d   = '0;
            prog_len_d = '0;
        end
        // nop_sel only moves with an accepted fetch so instr_out holds between requests.
        if (fetch_acc) begin
            nop_sel_d = addr_oob;
        end
    end

    always_comb begin
        load_ready  = load_ready_q;
        start       = start_q;
        running     = (state_q == RUN);
        prog_len    = prog_len_q;
        instr_valid = resp_valid_q && !branch_taken;
        fetch_oob   = resp_valid_q && nop_sel_q;
        instr_out   = nop_sel_q ? NOP_WORD[IW-1:0] : rd_word[IW-1:0];
`ifdef IMEM_PARITY_EN
        instr_perr  = !nop_sel_q && ((^rd_word[IW-1:0]) != rd_word[IW]);
`endif
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: load, fetch, out-of-range, flush, wrap-guard, reset and reload.
module tb_instr_mem_fetch;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_last;
    logic       reload;
    logic       start;
    logic       running;
    logic [4:0] prog_len;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic       branch_taken;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       fetch_oob;

    int n_checks = 0;
    int n_errors = 0;

    instr_mem_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .reload       (reload),
        .start        (start),
        .running      (running),
        .prog_len     (prog_len),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .branch_taken (branch_taken),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .fetch_oob    (fetch_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("check %s = %0h", tag, got);
        end
    endtask

    // Presents one loader beat for one cycle; returns at the following negedge.
    task automatic load_beat(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        $display("load beat data=%02h last=%0b", d, last);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0; branch_taken = 1'b0;

        #2;
        chk("rst_ready", load_ready, 0);
        chk("rst_running", running, 0);
        chk("rst_start", start, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_oob", fetch_oob, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_release", load_ready, 1);

        // 1. Load A1, B2, C3 with last on C3.
        load_beat(8'hA1, 1'b0);
        load_beat(8'hB2, 1'b0);
        load_beat(8'hC3, 1'b1);
        load_valid = 1'b0; load_last = 1'b0;
        #1;
        chk("t1_prog_len", prog_len, 3);
        chk("t1_start", start, 1);
        chk("t1_running", running, 1);
        chk("t1_ready", load_ready, 0);
        @(negedge clk);
        #1;
        chk("t1_start_one_cycle", start, 0);

        // 2. Back-to-back fetches of 0, 1, 2.
        fetch_req = 1'b1; fetch_addr = 4'd0;
        @(negedge clk);
        fetch_addr = 4'd1;
        #1;
        chk("t2_valid0", instr_valid, 1);
        chk("t2_instr0", instr_out, 8'hA1);
        @(negedge clk);
        fetch_addr = 4'd2;
        #1;
        chk("t2_valid1", instr_valid, 1);
        chk("t2_instr1", instr_out, 8'hB2);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("t2_valid2", instr_valid, 1);
        chk("t2_instr2", instr_out, 8'hC3);
        chk("t2_oob2", fetch_oob, 0);
        @(negedge clk);
        #1;
        chk("t2_idle_valid", instr_valid, 0);
        chk("t2_idle_hold", instr_out, 8'hC3);

        // 3. Out-of-range fetches: addr 5, then addr 3 == prog_len.
        fetch_req = 1'b1; fetch_addr = 4'd5;
        @(negedge clk);
        fetch_addr = 4'd3;
        #1;
        chk("t3_valid5", instr_valid, 1);
        chk("t3_instr5", instr_out, 0);
        chk("t3_oob5", fetch_oob, 1);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("t3_valid3", instr_valid, 1);
        chk("t3_instr3", instr_out, 0);
        chk("t3_oob3", fetch_oob, 1);

        // 4. Fetch 1, then branch to 0: B2 killed, A1 follows.
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 4'd1;
        @(negedge clk);
        branch_taken = 1'b1; fetch_addr = 4'd0;
        #1;
        chk("t4_killed", instr_valid, 0);
        @(negedge clk);
        branch_taken = 1'b0; fetch_req = 1'b0;
        #1;
        chk("t4_target_valid", instr_valid, 1);
        chk("t4_target_instr", instr_out, 8'hA1);
        chk("t4_target_oob", fetch_oob, 0);

        // Reload with a simultaneous fetch: reload wins, no response.
        @(negedge clk);
        reload = 1'b1; fetch_req = 1'b1; fetch_addr = 4'd0;
        @(negedge clk);
        reload = 1'b0; fetch_req = 1'b0;
        #1;
        chk("rl_ready", load_ready, 1);
        chk("rl_running", running, 0);
        chk("rl_prog_len", prog_len, 0);
        chk("rl_valid", instr_valid, 0);

        // 5. Sixteen words without load_last: wrap guard ends the load.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                #1;
                chk("t5_still_load", running, 0);
                chk("t5_len15", prog_len, 15);
            end
            load_beat(8'h10 + 8'(i), 1'b0);
        end
        load_valid = 1'b0;
        #1;
        chk("t5_running", running, 1);
        chk("t5_prog_len", prog_len, 16);
        chk("t5_start", start, 1);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 4'd15;
        @(negedge clk);
        fetch_addr = 4'd0;
        #1;
        chk("t5_instr15", instr_out, 8'h1F);
        chk("t5_oob15", fetch_oob, 0);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("t5_instr0", instr_out, 8'h10);

        // 6a. Asynchronous reset mid-RUN with a valid response on the outputs.
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 4'd1;
        #6;
        chk("t6_pre_valid", instr_valid, 1);
        chk("t6_pre_instr", instr_out, 8'h11);
        rst_n = 1'b0;
        #1;
        chk("t6_run_running", running, 0);
        chk("t6_run_valid", instr_valid, 0);
        chk("t6_run_instr", instr_out, 0);
        chk("t6_run_prog_len", prog_len, 0);
        chk("t6_run_ready", load_ready, 0);
        chk("t6_run_oob", fetch_oob, 0);
        fetch_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_ready_again", load_ready, 1);

        // 6b. Asynchronous reset mid-LOAD, then a fresh program.
        load_beat(8'h55, 1'b0);
        load_beat(8'h66, 1'b0);
        load_valid = 1'b0;
        #1;
        chk("t6_load_len2", prog_len, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_load_prog_len", prog_len, 0);
        chk("t6_load_running", running, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_beat(8'h77, 1'b0);
        load_beat(8'h88, 1'b1);
        load_valid = 1'b0; load_last = 1'b0;
        #1;
        chk("t6_new_len", prog_len, 2);
        chk("t6_new_start", start, 1);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 4'd0;
        @(negedge clk);
        fetch_addr = 4'd1;
        #1;
        chk("t6_new_instr0", instr_out, 8'h77);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("t6_new_instr1", instr_out, 8'h88);
        chk("t6_new_valid1", instr_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
